// File: rtl/mb_rx.sv
// mb_rx: mainband receive logical PHY for a 16-lane die-to-die link.
//
// The block collects 8-UI bursts framed by valid_iPin. Each burst delivers 16 bytes,
// one byte per lane, LSB first. Four good bursts make one 64-byte flit. A finished
// flit goes into a small FIFO. The FIFO is drained one flit per cycle onto data_o,
// and valid_o is asserted for that cycle. There is no backpressure.
//
// Ports:
//   clk               sole clock; every rising edge samples one UI
//   reset             asynchronous, active-high reset
//   valid_iPin        mainband valid lane (1,1,1,1,0,0,0,0 over a burst)
//   periph_clkPins_i  forwarded clock pair, accepted and ignored
//   dataPins_i        16 data lanes, bit l is lane l
//   valid_o           one-cycle strobe, data_o holds a new flit
//   data_o            received flit, element i is flit byte i
module mb_rx #(
  parameter int flit_buffer_size = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        valid_iPin,
  input  logic [1:0]  periph_clkPins_i,
  input  logic [15:0] dataPins_i,
  output logic        valid_o,
  output logic [7:0]  data_o [63:0]
);

  localparam int AW = $clog2(flit_buffer_size);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  // ST_WAIT_LOW: valid stayed high into UI 4..7. The framer must see valid low
  // before it accepts a new burst start.
  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_BURST    = 2'd1,
    ST_WAIT_LOW = 2'd2
  } state_e;

  state_e       state_q;
  logic [2:0]   ui_q;
  logic [1:0]   chunk_q;
  logic [511:0] asm_q;
  logic [511:0] asm_d;
  logic [511:0] mem_q [flit_buffer_size];
  logic [AW:0]  wr_ptr_q;
  logic [AW:0]  rd_ptr_q;

  logic frame_err_s;
  logic sample_s;
  logic push_s;
  logic empty_s;
  logic full_s;
  logic unused_pins_s;

  // The forwarded clocks carry no information this block needs.
  assign unused_pins_s = ^periph_clkPins_i;

  // Framing check, sample enable and flit-complete detection.
  always_comb begin
    frame_err_s = 1'b0;
    if (state_q == ST_BURST) begin
      if (ui_q <= 3'd3) begin
        frame_err_s = ~valid_iPin;
      end else begin
        frame_err_s = valid_iPin;
      end
    end else begin
      frame_err_s = 1'b0;
    end
    sample_s = ((state_q == ST_IDLE) && valid_iPin) ||
               ((state_q == ST_BURST) && !frame_err_s);
    push_s   = (state_q == ST_BURST) && !frame_err_s &&
               (ui_q == 3'd7) && (chunk_q == 2'd3);
  end

  // Merge this UI's lane bits into the assembly register. The bit index is
  // {chunk, lane, ui}, which equals (16*chunk + lane)*8 + ui.
  always_comb begin
    asm_d = asm_q;
    if (sample_s) begin
      for (int l = 0; l < 16; l++) begin
        asm_d[{chunk_q, 4'(l), ui_q}] = dataPins_i[l];
      end
    end else begin
      asm_d = asm_q;
    end
  end

  // Burst framer FSM: UI and chunk counters and flit assembly.
  // In ST_IDLE ui_q is 0, so the edge that starts a burst samples UI 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      ui_q    <= 3'd0;
      chunk_q <= 2'd0;
      asm_q   <= '0;
    end else begin
      asm_q <= asm_d;
      case (state_q)
        ST_IDLE: begin
          if (valid_iPin) begin
            state_q <= ST_BURST;
            ui_q    <= 3'd1;
          end
        end
        ST_BURST: begin
          if (frame_err_s) begin
            // Stale bytes left in asm_q are overwritten before the next push.
            ui_q    <= 3'd0;
            chunk_q <= 2'd0;
            state_q <= valid_iPin ? ST_WAIT_LOW : ST_IDLE;
          end else if (ui_q == 3'd7) begin
            ui_q    <= 3'd0;
            chunk_q <= chunk_q + 2'd1;
            state_q <= ST_IDLE;
          end else begin
            ui_q <= ui_q + 3'd1;
          end
        end
        ST_WAIT_LOW: begin
          if (!valid_iPin) begin
            state_q <= ST_IDLE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          ui_q    <= 3'd0;
          chunk_q <= 2'd0;
        end
      endcase
    end
  end

  assign empty_s = (wr_ptr_q == rd_ptr_q);
  assign full_s  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  // FIFO storage. When the FIFO is full, the incoming flit is dropped.
  always_ff @(posedge clk) begin
    if (push_s && !full_s) begin
      mem_q[wr_ptr_q[AW-1:0]] <= asm_d;
    end
  end

  // FIFO pointers and output register. The head is popped on every edge where
  // the FIFO is non-empty.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      valid_o  <= 1'b0;
      for (int i = 0; i < 64; i++) begin
        data_o[i] <= 8'h00;
      end
    end else begin
      if (push_s && !full_s) begin
        wr_ptr_q <= wr_ptr_q + PTR_ONE;
      end
      if (!empty_s) begin
        valid_o <= 1'b1;
        for (int i = 0; i < 64; i++) begin
          data_o[i] <= mem_q[rd_ptr_q[AW-1:0]][i*8 +: 8];
        end
        rd_ptr_q <= rd_ptr_q + PTR_ONE;
      end else begin
        valid_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mb_rx.sv
// tb_mb_rx: self-checking bench for mb_rx.
// The main part is a table of flits sent back to back. Each record lists the flit
// and the bytes expected at hand-computed positions.
// Hand-written sequences cover framing errors and reset in the middle of a flit.
// A negedge monitor records every valid_o pulse together with its cycle number.
module tb_mb_rx;

  logic        clk = 1'b0;
  logic        reset;
  logic        valid_iPin;
  logic [1:0]  periph_clkPins_i;
  logic [15:0] dataPins_i;
  logic        valid_o;
  logic [7:0]  data_o [63:0];

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  logic [511:0] got_q [$];
  int           got_cyc [$];

  typedef struct {
    logic [511:0] flit;
    int           idx0;
    logic [7:0]   exp0;
    int           idx1;
    logic [7:0]   exp1;
    int           idx2;
    logic [7:0]   exp2;
  } vec_t;

  vec_t vecs [4];
  int   last_cyc [4];

  always #5 clk = ~clk;
  assign periph_clkPins_i = {~clk, clk};

  mb_rx #(.flit_buffer_size(4)) dut (
    .clk              (clk),
    .reset            (reset),
    .valid_iPin       (valid_iPin),
    .periph_clkPins_i (periph_clkPins_i),
    .dataPins_i       (dataPins_i),
    .valid_o          (valid_o),
    .data_o           (data_o)
  );

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [511:0] dout_flat();
    logic [511:0] r;
    for (int i = 0; i < 64; i++) r[i*8 +: 8] = data_o[i];
    return r;
  endfunction

  always @(negedge clk) begin
    if (valid_o === 1'b1) begin
      got_q.push_back(dout_flat());
      got_cyc.push_back(cyc);
    end
  end

  function automatic logic [511:0] str2flit(input string s);
    logic [511:0] f;
    for (int i = 0; i < 64; i++) f[i*8 +: 8] = (i < s.len()) ? s[i] : 8'h20;
    return f;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_flit(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One 8-UI burst. err_ui >= 0 inverts valid at that UI, and the rest of the
  // burst is then driven idle.
  task automatic send_burst(input logic [127:0] b, input int err_ui);
    bit abort;
    abort = 1'b0;
    for (int u = 0; u < 8; u++) begin
      @(negedge clk);
      if (abort) begin
        valid_iPin = 1'b0;
        dataPins_i = 16'h0000;
      end else begin
        valid_iPin = (u < 4) ? 1'b1 : 1'b0;
        if (u == err_ui) begin
          valid_iPin = ~valid_iPin;
          abort = 1'b1;
        end
        for (int l = 0; l < 16; l++) dataPins_i[l] = b[l*8 + u];
      end
    end
  endtask

  task automatic send_flit(input logic [511:0] f);
    for (int c = 0; c < 4; c++) send_burst(f[c*128 +: 128], -1);
  endtask

  task automatic clear_mon();
    got_q.delete();
    got_cyc.delete();
  endtask

  logic [511:0] lm;
  logic [511:0] fa;
  logic [511:0] fb;
  logic [511:0] fc;
  logic [511:0] fd;
  logic [511:0] fe;

  initial begin
    reset      = 1'b1;
    valid_iPin = 1'b0;
    dataPins_i = 16'h0000;
    #1;
    chk("reset_valid", {63'd0, valid_o}, 64'd0);
    chk_flit("reset_data", dout_flat(), 512'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Table: four flits sent back to back.
    lm = '0;
    lm[47*8 +: 8] = 8'hA5;
    vecs[0] = '{str2flit("Hello, World! This is a test. Flit 0"), 0, 8'h48, 35, 8'h30, 63, 8'h20};
    vecs[1] = '{str2flit("This is Flit 1. It has more data"), 0, 8'h54, 13, 8'h31, 40, 8'h20};
    vecs[2] = '{str2flit("Flit 2. This is the last one."), 0, 8'h46, 5, 8'h32, 63, 8'h20};
    vecs[3] = '{lm, 47, 8'hA5, 32, 8'h00, 46, 8'h00};

    clear_mon();
    for (int i = 0; i < 4; i++) begin
      send_flit(vecs[i].flit);
      last_cyc[i] = cyc;
    end
    repeat (6) @(posedge clk);
    @(negedge clk);
    chk("b2b_count", 64'(got_q.size()), 64'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < got_q.size()) begin
        chk_flit("b2b_flit", got_q[i], vecs[i].flit);
        chk("b2b_byte_a", {56'd0, got_q[i][vecs[i].idx0*8 +: 8]}, {56'd0, vecs[i].exp0});
        chk("b2b_byte_b", {56'd0, got_q[i][vecs[i].idx1*8 +: 8]}, {56'd0, vecs[i].exp1});
        chk("b2b_byte_c", {56'd0, got_q[i][vecs[i].idx2*8 +: 8]}, {56'd0, vecs[i].exp2});
        chk("b2b_latency", 64'(got_cyc[i]), 64'(last_cyc[i] + 2));
      end
      if (i > 0 && i < got_q.size()) begin
        chk("b2b_spacing", 64'(got_cyc[i] - got_cyc[i-1]), 64'd32);
      end
    end

    // Framing error: valid drops at UI 2 of chunk 1, then a clean flit follows.
    for (int i = 0; i < 64; i++) fa[i*8 +: 8] = 8'(i + 128);
    fb = str2flit("Clean flit after framing error");
    clear_mon();
    send_burst(fa[127:0], -1);
    send_burst(fa[255:128], 2);
    send_flit(fb);
    repeat (6) @(posedge clk);
    @(negedge clk);
    chk("ferr_low_count", 64'(got_q.size()), 64'd1);
    if (got_q.size() > 0) chk_flit("ferr_low_flit", got_q[0], fb);

    // Framing error: valid stays high for 8 UIs. The UI 4 edge must not start a
    // new burst.
    fc = str2flit("Flit after long valid");
    clear_mon();
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      valid_iPin = (k < 8) ? 1'b1 : 1'b0;
      dataPins_i = (k < 8) ? 16'hFFFF : 16'h0000;
    end
    send_flit(fc);
    repeat (6) @(posedge clk);
    @(negedge clk);
    chk("ferr_high_count", 64'(got_q.size()), 64'd1);
    if (got_q.size() > 0) chk_flit("ferr_high_flit", got_q[0], fc);

    // Reset after two chunks. Outputs must clear at once, without waiting for a
    // clock edge.
    for (int i = 0; i < 64; i++) fd[i*8 +: 8] = 8'(255 - i);
    fe = str2flit("Post-reset flit data");
    clear_mon();
    send_burst(fd[127:0], -1);
    send_burst(fd[255:128], -1);
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("midreset_valid", {63'd0, valid_o}, 64'd0);
    chk_flit("midreset_data", dout_flat(), 512'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    send_flit(fe);
    repeat (6) @(posedge clk);
    @(negedge clk);
    chk("midreset_count", 64'(got_q.size()), 64'd1);
    if (got_q.size() > 0) chk_flit("midreset_flit", got_q[0], fe);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
